line_memory_ctrl: RTL and testbench

// - Parametrised main-memory model on the C2 cache<->memory bus; successor of the fixed-size memory.
// - Serves READ_LINE/WRITE_LINE bursts of LINE_BYTES over a BUS_BYTES-wide shared tristate data bus.
// - Adds programmable access latency, write acknowledge, atomic line commit and posedge-only timing.
// - Sits below the cache, sole slave on the C2 bus.

---
 rtl/c2_bus_pkg.sv | 23 ++
 rtl/c2_bus_port.sv | 18 +
 rtl/line_memory_ctrl.sv | 161 ++++++++++++++++
 tb/tb_line_memory_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/c2_bus_pkg.sv
// Shared definitions for the C2 cache<->memory bus: command encodings and
// the memory-side FSM state type.
package c2_bus_pkg;

    localparam int unsigned BITS_IN_BYTE = 8;

    typedef enum logic [1:0] {
        NOP        = 2'b00,
        RESPONSE   = 2'b01,
        READ_LINE  = 2'b10,
        WRITE_LINE = 2'b11
    } c2_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        WR_BEATS,
        WR_WAIT,
        WR_ACK,
        RD_WAIT,
        RD_BEATS
    } mem_state_t;

endpackage

// File: rtl/c2_bus_port.sv
// Tristate drivers for the shared C2 command and data buses. The memory
// drives both buses only while it owns them; otherwise they float.
module c2_bus_port
    import c2_bus_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              owner_i,
    input  logic [1:0]        cmd_i,
    input  logic [DATA_W-1:0] data_i,
    inout  logic [1:0]        cmd_io,
    inout  logic [DATA_W-1:0] data_io
);

    assign cmd_io  = owner_i ? cmd_i  : 'z;
    assign data_io = owner_i ? data_i : 'z;

endmodule

// File: rtl/line_memory_ctrl.sv
// Line-oriented main-memory model on the C2 bus. Accepts READ_LINE and
// WRITE_LINE bursts, applies programmable latencies, commits written lines
// atomically and acknowledges writes with a single RESPONSE cycle.
module line_memory_ctrl
    import c2_bus_pkg::*;
#(
    parameter int unsigned MEM_BYTES  = 524288,
    parameter int unsigned LINE_BYTES = 16,
    parameter int unsigned BUS_BYTES  = 2,
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned RD_LATENCY = 4,
    parameter int unsigned WR_LATENCY = 4,
    parameter string       INIT_FILE  = ""
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             dump,
    input  logic [ADDR_W-1:0]                addr,
    inout  logic [BUS_BYTES*BITS_IN_BYTE-1:0] data_w,
    inout  logic [1:0]                       cmd_w,
    output logic                             busy
);

    localparam int unsigned BEATS   = LINE_BYTES / BUS_BYTES;
    localparam int unsigned LINES   = MEM_BYTES / LINE_BYTES;
    localparam int unsigned LINE_AW = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int unsigned BUS_W   = BUS_BYTES * BITS_IN_BYTE;
    localparam int unsigned LINE_W  = LINE_BYTES * BITS_IN_BYTE;
    localparam int unsigned BEAT_W  = $clog2(BEATS) + 1;
    localparam int unsigned MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int unsigned LAT_W   = $clog2(MAX_LAT + 1) + 1;
    localparam int unsigned RD_LAST = (RD_LATENCY > 0) ? RD_LATENCY - 1 : 0;
    localparam int unsigned WR_LAST = (WR_LATENCY > 0) ? WR_LATENCY - 1 : 0;
    localparam bit          HAS_INIT = (INIT_FILE != "");

    // Storage is one word per line; byte b of a line sits at bits [8b+7:8b].
    // Truncating the line address to LINE_AW bits gives the modulo wrap.
    logic [LINE_W-1:0]  mem_q [LINES];

    mem_state_t         state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [LINE_AW-1:0] line_q, line_d;
    logic [LINE_W-1:0]  buf_q, buf_d;
    logic               mem_we;
    logic               owner;
    logic [BUS_W-1:0]   data_out;

    // Preload and dump are simulation conveniences left to the environment.
    logic unused_sim;
    assign unused_sim = dump ^ HAS_INIT;

    assign busy = (state_q != IDLE);

    // State, counters and line buffer; reset aborts any burst in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            lat_q   <= '0;
            line_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            line_q  <= line_d;
            buf_q   <= buf_d;
        end
    end

    // Atomic commit of the assembled line (including the final beat).
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[line_d] <= buf_d;
        end
    end

    // Next-state, beat capture/launch and bus ownership.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        lat_d    = lat_q;
        line_d   = line_q;
        buf_d    = buf_q;
        mem_we   = 1'b0;
        owner    = 1'b0;
        data_out = '0;
        unique case (state_q)
            IDLE: begin
                if (cmd_w == WRITE_LINE) begin
                    line_d             = LINE_AW'(addr);
                    buf_d[0 +: BUS_W]  = data_w;
                    beat_d             = BEAT_W'(1);
                    lat_d              = '0;
                    if (BEATS == 1) begin
                        mem_we  = 1'b1;
                        state_d = (WR_LATENCY == 0) ? WR_ACK : WR_WAIT;
                    end else begin
                        state_d = WR_BEATS;
                    end
                end else if (cmd_w == READ_LINE) begin
                    line_d  = LINE_AW'(addr);
                    lat_d   = '0;
                    state_d = RD_WAIT;
                end
            end
            WR_BEATS: begin
                buf_d[BUS_W*int'(beat_q) +: BUS_W] = data_w;
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    mem_we  = 1'b1;
                    lat_d   = '0;
                    state_d = (WR_LATENCY == 0) ? WR_ACK : WR_WAIT;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            WR_WAIT: begin
                if (lat_q == LAT_W'(WR_LAST)) begin
                    state_d = WR_ACK;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            WR_ACK: begin
                owner   = 1'b1;
                state_d = IDLE;
            end
            RD_WAIT: begin
                if (lat_q == LAT_W'(RD_LAST)) begin
                    buf_d   = mem_q[line_q];
                    beat_d  = '0;
                    state_d = RD_BEATS;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            RD_BEATS: begin
                owner    = 1'b1;
                data_out = buf_q[BUS_W*int'(beat_q) +: BUS_W];
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    state_d = IDLE;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    c2_bus_port #(
        .DATA_W (BUS_W)
    ) u_port (
        .owner_i (owner),
        .cmd_i   (RESPONSE),
        .data_i  (data_out),
        .cmd_io  (cmd_w),
        .data_io (data_w)
    );

endmodule

// File: tb/tb_line_memory_ctrl.sv
// Directed bench for line_memory_ctrl: default configuration plus two swept
// geometries (1-byte bus / 4-byte lines, 4-byte bus / 64-byte lines).
module tb_line_memory_ctrl;
    import c2_bus_pkg::*;

    logic        clk;
    logic        reset;
    int          sel;
    logic        drv;
    logic [1:0]  tb_cmd;
    logic [31:0] tb_data;
    int          tb_addr;
    int          n_checks;
    int          n_fail;

    // per-DUT geometry: index 0 = default, 1 = sweep A, 2 = sweep B
    int BB [3] = '{2, 1, 4};
    int LB [3] = '{16, 4, 64};
    int RL [3] = '{4, 1, 1};
    int WL [3] = '{4, 0, 0};
    int LN [3] = '{32768, 256, 64};

    wire [1:0]  cmd0, cmd1, cmd2;
    wire [15:0] data0;
    wire [7:0]  data1;
    wire [31:0] data2;
    logic       busy0, busy1, busy2;
    logic [14:0] addr0;
    logic [9:0]  addr1;
    logic [7:0]  addr2;

    assign addr0 = tb_addr[14:0];
    assign addr1 = tb_addr[9:0];
    assign addr2 = tb_addr[7:0];
    assign cmd0  = (drv && sel == 0) ? tb_cmd : 2'bz;
    assign cmd1  = (drv && sel == 1) ? tb_cmd : 2'bz;
    assign cmd2  = (drv && sel == 2) ? tb_cmd : 2'bz;
    assign data0 = (drv && sel == 0) ? tb_data[15:0] : 16'bz;
    assign data1 = (drv && sel == 1) ? tb_data[7:0] : 8'bz;
    assign data2 = (drv && sel == 2) ? tb_data : 32'bz;

    line_memory_ctrl u_dut0 (
        .clk (clk), .reset (reset), .dump (1'b0), .addr (addr0),
        .data_w (data0), .cmd_w (cmd0), .busy (busy0)
    );

    line_memory_ctrl #(
        .MEM_BYTES (1024), .LINE_BYTES (4), .BUS_BYTES (1), .ADDR_W (10),
        .RD_LATENCY (1), .WR_LATENCY (0)
    ) u_dut1 (
        .clk (clk), .reset (reset), .dump (1'b0), .addr (addr1),
        .data_w (data1), .cmd_w (cmd1), .busy (busy1)
    );

    line_memory_ctrl #(
        .MEM_BYTES (4096), .LINE_BYTES (64), .BUS_BYTES (4), .ADDR_W (8),
        .RD_LATENCY (1), .WR_LATENCY (0)
    ) u_dut2 (
        .clk (clk), .reset (reset), .dump (1'b0), .addr (addr2),
        .data_w (data2), .cmd_w (cmd2), .busy (busy2)
    );

    logic [1:0]  obs_cmd;
    logic [31:0] obs_data;
    logic        obs_busy;

    always_comb begin
        obs_cmd  = cmd0;
        obs_data = {16'h0, data0};
        obs_busy = busy0;
        if (sel == 1) begin
            obs_cmd  = cmd1;
            obs_data = {24'h0, data1};
            obs_busy = busy1;
        end else if (sel == 2) begin
            obs_cmd  = cmd2;
            obs_data = data2;
            obs_busy = busy2;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s dut=%0d got=%0h expected=%0h", tag, sel, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat_of(input logic [511:0] line, input int k, input int bits);
        logic [511:0] sh;
        logic [63:0]  m;
        sh = line >> (k * bits);
        m  = (64'd1 << bits) - 64'd1;
        return sh[31:0] & m[31:0];
    endfunction

    task automatic do_write(input int a, input logic [511:0] line, input bit inject);
        int nb;
        int bits;
        int first;
        int resp_n;
        nb     = LB[sel] / BB[sel];
        bits   = BB[sel] * 8;
        first  = 0;
        resp_n = 0;
        @(negedge clk);
        tb_addr = a;
        tb_cmd  = WRITE_LINE;
        drv     = 1'b1;
        for (int k = 0; k < nb; k++) begin
            if (k > 0) @(negedge clk);
            tb_data = beat_of(line, k, bits);
        end
        for (int i = 1; i <= WL[sel] + 6; i++) begin
            @(negedge clk);
            if (i == 1 && inject) begin
                tb_cmd  = READ_LINE;
                tb_addr = a + 1;
            end else begin
                drv = 1'b0;
            end
            #1;
            if (obs_cmd == RESPONSE) begin
                resp_n++;
                if (first == 0) first = i;
            end
        end
        check_eq("wr_ack_pos", 64'(first), 64'(WL[sel] + 1));
        check_eq("wr_ack_len", 64'(resp_n), 64'd1);
        check_eq("wr_idle", 64'(obs_busy), 64'd0);
    endtask

    task automatic do_read(input int a, input logic [511:0] line);
        int nb;
        int bits;
        int rl;
        bit exp_resp;
        nb   = LB[sel] / BB[sel];
        bits = BB[sel] * 8;
        rl   = RL[sel];
        @(negedge clk);
        tb_addr = a;
        tb_cmd  = READ_LINE;
        drv     = 1'b1;
        for (int i = 1; i <= rl + nb + 2; i++) begin
            @(negedge clk);
            drv = 1'b0;
            #1;
            exp_resp = (i >= rl + 1) && (i <= rl + nb);
            check_eq("rd_cmd_known", 64'($isunknown(obs_cmd)), 64'd0);
            check_eq("rd_resp", 64'(obs_cmd == RESPONSE), 64'(exp_resp));
            if (exp_resp) begin
                check_eq("rd_data", 64'(obs_data), 64'(beat_of(line, i - rl - 1, bits)));
            end
        end
        check_eq("rd_idle", 64'(obs_busy), 64'd0);
    endtask

    logic [511:0] line3;
    logic [511:0] line5;
    logic [511:0] rline;
    logic [511:0] sb [int];
    int           ra;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        sel      = 0;
        drv      = 1'b0;
        tb_cmd   = NOP;
        tb_data  = '0;
        tb_addr  = 0;
        reset    = 1'b1;
        line3    = '0;
        line5    = '0;
        for (int b = 0; b < 16; b++) begin
            line3[b*8 +: 8] = 8'(b);
            line5[b*8 +: 8] = 8'(8'hA0 + b);
        end

        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check_eq("rst_busy", 64'(obs_busy), 64'd0);
            check_eq("rst_cmd", 64'(obs_cmd == RESPONSE), 64'd0);
        end
        sel = 0;
        @(negedge clk);
        reset = 1'b0;

        do_write(3, line3, 1'b0);
        do_read(3, line3);
        do_read(32768 + 3, line3);

        do_write(5, line5, 1'b1);
        do_read(5, line5);

        // reset lands while the third beat of a read is on the bus
        @(negedge clk);
        tb_addr = 3;
        tb_cmd  = READ_LINE;
        drv     = 1'b1;
        for (int i = 1; i <= RL[0] + 3; i++) begin
            @(negedge clk);
            drv = 1'b0;
        end
        #1;
        check_eq("pre_rst_resp", 64'(obs_cmd == RESPONSE), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_cmd", 64'(obs_cmd == RESPONSE), 64'd0);
        check_eq("mid_rst_busy", 64'(obs_busy), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        do_read(3, line3);

        for (int s = 1; s < 3; s++) begin
            sel = s;
            sb.delete();
            for (int n = 0; n < 6; n++) begin
                ra = int'($urandom_range(0, 2 * LN[s] - 1));
                for (int w = 0; w < 16; w++) rline[w*32 +: 32] = $urandom();
                if (LB[s] < 64) rline &= (512'(1) << (LB[s] * 8)) - 512'(1);
                do_write(ra, rline, 1'b0);
                sb[ra % LN[s]] = rline;
            end
            foreach (sb[key]) begin
                do_read(key + LN[s], sb[key]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
